ahb_out_fifo: RTL and testbench

AHB-Lite slave output peripheral. It is the buffered, parametrised successor to the single-register LED/data output port. Software pushes words into a FIFO. The block presents them one at a time on DataOut/DataValid and advances on either a consumer handshake (DataReady) or a debounced push-button acknowledge. It sits on the AHB-Lite bus alongside the other word-addressed slaves and drives an external display or consumer.

---
 rtl/ahb_out_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_ahb_out_fifo.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_out_fifo.sv
// AHB-Lite output peripheral: software-fed FIFO presenting one word at a time on DataOut/DataValid,
// advanced by a DataReady handshake or a debounced acknowledge button.
module ahb_out_fifo #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8,
  parameter int DEBOUNCE_COUNT = 1250000
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [31:0]           HADDR,
  input  logic [31:0]           HWDATA,
  input  logic [2:0]            HSIZE,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic                  HREADY,
  input  logic                  HSEL,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  DataValid,
  input  logic                  DataReady,
  input  logic                  Buttons
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_ACK    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  logic                  ap_sel;
  logic                  wr_q;
  logic                  rd_q;
  logic [1:0]            addr_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic                  enable;
  logic                  mode;
  logic                  overflow;
  logic [7:0]            ack_count;

  logic                  push_req;
  logic                  push;
  logic                  ctrl_wr;
  logic                  flush;
  logic                  ack_rd;
  logic                  ack;
  logic                  consume;
  logic                  load;

  logic                  btn_s1;
  logic                  btn_s2;
  logic                  btn_db;
  logic                  btn_rise;

  // absorbs bus bits this slave never decodes
  logic                  unused_bus;
  assign unused_bus = ^{HADDR[31:4], HADDR[1:0], HSIZE, HWDATA};

  assign HREADYOUT = 1'b1;
  assign ap_sel    = HREADY & HSEL & (HTRANS != 2'b00);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      addr_q <= 2'd0;
    end else begin
      wr_q   <= ap_sel & HWRITE;
      rd_q   <= ap_sel & ~HWRITE;
      addr_q <= HADDR[3:2];
    end
  end

  assign push_req   = wr_q && (addr_q == A_DATA);
  assign ctrl_wr    = wr_q && (addr_q == A_CTRL);
  assign flush      = ctrl_wr && HWDATA[2];
  assign ack_rd     = rd_q && (addr_q == A_ACK);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign push       = push_req & ~fifo_full;

  assign ack        = mode ? btn_rise : DataReady;
  assign consume    = DataValid & ack;
  // flush wins over a load on the same edge so DataOut keeps its value
  assign load       = enable & ~fifo_empty & (~DataValid | ack) & ~flush;

  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wptr] <= HWDATA[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (load) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(load);
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      DataOut   <= '0;
      DataValid <= 1'b0;
    end else if (flush) begin
      DataValid <= 1'b0;
    end else if (load) begin
      DataOut   <= mem[rptr];
      DataValid <= 1'b1;
    end else if (consume) begin
      DataValid <= 1'b0;
    end
  end

  // a word dropped because the FIFO was full stays flagged until a flush
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ack_count <= 8'd0;
    end else if (ack_rd) begin
      ack_count <= consume ? 8'd1 : 8'd0;
    end else if (consume && (ack_count != 8'hFF)) begin
      ack_count <= ack_count + 8'd1;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      enable <= 1'b1;
      mode   <= 1'b0;
    end else if (ctrl_wr) begin
      enable <= HWDATA[0];
      mode   <= HWDATA[1];
    end
  end

  always_comb begin
    HRDATA = 32'd0;
    if (rd_q) begin
      case (addr_q)
        A_DATA:   HRDATA = 32'(DataOut);
        A_STATUS: HRDATA = {16'd0, 8'(count), 4'd0, overflow, fifo_full, fifo_empty, DataValid};
        A_ACK:    HRDATA = {24'd0, ack_count};
        A_CTRL:   HRDATA = {30'd0, mode, enable};
        default:  HRDATA = 32'd0;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
    end else begin
      btn_s1 <= Buttons;
      btn_s2 <= btn_s1;
    end
  end

  generate
    if (DEBOUNCE_COUNT == 0) begin : g_nodb
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          btn_db   <= 1'b0;
          btn_rise <= 1'b0;
        end else begin
          btn_db   <= btn_s2;
          btn_rise <= btn_s2 & ~btn_db;
        end
      end
    end else begin : g_db
      localparam int DW = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;
      localparam logic [DW-1:0] RELOAD = DW'(DEBOUNCE_COUNT - 1);
      logic [DW-1:0] db_cnt;

      // down-counter restarts whenever the synchronised input agrees with the accepted level
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
          db_cnt   <= RELOAD;
          btn_db   <= 1'b0;
          btn_rise <= 1'b0;
        end else begin
          btn_rise <= 1'b0;
          if (btn_s2 == btn_db) begin
            db_cnt <= RELOAD;
          end else if (db_cnt == '0) begin
            btn_db   <= btn_s2;
            btn_rise <= btn_s2;
            db_cnt   <= RELOAD;
          end else begin
            db_cnt <= db_cnt - DW'(1);
          end
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ahb_out_fifo.sv
// Bench for ahb_out_fifo: register-level vector table, directed corner sequences,
// then randomized traffic against a queue-based reference model.
module tb_ahb_out_fifo;

  localparam int OP_IDLE = 0;
  localparam int OP_WR   = 1;
  localparam int OP_RD   = 2;

  typedef struct {
    int          op;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        ready;
    logic [31:0] exp_rd;
    logic        exp_dv;
    logic [31:0] exp_dout;
  } vec_t;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic [31:0] DataOut;
  logic        DataValid;
  logic        DataReady;
  logic        Buttons;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_q[$];
  logic        m_dv;
  logic [31:0] m_dout;
  logic        m_ovf;
  int          m_ack;
  logic        m_en;
  logic        m_mode;

  vec_t        vecs[17];
  logic [31:0] rd;

  always #5 HCLK = ~HCLK;

  ahb_out_fifo #(
    .DATA_WIDTH(32),
    .FIFO_DEPTH(8),
    .DEBOUNCE_COUNT(4)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .HADDR(HADDR),
    .HWDATA(HWDATA),
    .HSIZE(HSIZE),
    .HTRANS(HTRANS),
    .HWRITE(HWRITE),
    .HREADY(HREADY),
    .HSEL(HSEL),
    .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT),
    .DataOut(DataOut),
    .DataValid(DataValid),
    .DataReady(DataReady),
    .Buttons(Buttons)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb_write(input logic [3:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {28'd0, a};
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    tick();
  endtask

  task automatic ahb_read(input logic [3:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {28'd0, a};
    tick();
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
    tick();
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    case (sel)
      2'd0:    return m_dout;
      2'd1:    return {16'd0, 8'(m_q.size()), 4'd0, m_ovf, m_q.size() == 8, m_q.size() == 0, m_dv};
      2'd2:    return 32'(m_ack);
      default: return {30'd0, m_mode, m_en};
    endcase
  endfunction

  // one clock edge of the reference, evaluated from the pre-edge state
  function automatic void model_edge(input logic push, input logic [31:0] wd, input logic ctrl_wr,
                                     input logic ack_rd, input logic ack);
    logic consume;
    logic was_full;
    logic flush;
    logic load;
    consume  = m_dv && ack;
    was_full = (m_q.size() == 8);
    flush    = ctrl_wr && wd[2];
    load     = m_en && (m_q.size() > 0) && (!m_dv || ack) && !flush;
    if (ack_rd) m_ack = consume ? 1 : 0;
    else if (consume && m_ack < 255) m_ack = m_ack + 1;
    if (flush) begin
      m_q.delete();
      m_dv  = 1'b0;
      m_ovf = 1'b0;
    end else begin
      if (load) begin
        m_dout = m_q.pop_front();
        m_dv   = 1'b1;
      end else if (consume) begin
        m_dv = 1'b0;
      end
      if (push) begin
        if (was_full) m_ovf = 1'b1;
        else m_q.push_back(wd);
      end
    end
    if (ctrl_wr) begin
      m_en   = wd[0];
      m_mode = wd[1];
    end
  endfunction

  initial begin
    HRESETn = 1'b0; HADDR = 32'd0; HWDATA = 32'd0; HSIZE = 3'b010; HTRANS = 2'b00;
    HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0; DataReady = 1'b0; Buttons = 1'b0;

    vecs[0]  = '{OP_RD,   4'h4, 32'h0,  1'b0, 32'h2,   1'b0, 32'h0};
    vecs[1]  = '{OP_RD,   4'hC, 32'h0,  1'b0, 32'h1,   1'b0, 32'h0};
    vecs[2]  = '{OP_RD,   4'h8, 32'h0,  1'b0, 32'h0,   1'b0, 32'h0};
    vecs[3]  = '{OP_WR,   4'h0, 32'hA5, 1'b0, 32'h0,   1'b0, 32'h0};
    vecs[4]  = '{OP_IDLE, 4'h0, 32'h0,  1'b0, 32'h0,   1'b1, 32'hA5};
    vecs[5]  = '{OP_RD,   4'h4, 32'h0,  1'b0, 32'h3,   1'b1, 32'hA5};
    vecs[6]  = '{OP_IDLE, 4'h0, 32'h0,  1'b1, 32'h0,   1'b0, 32'hA5};
    vecs[7]  = '{OP_RD,   4'h8, 32'h0,  1'b0, 32'h1,   1'b0, 32'hA5};
    vecs[8]  = '{OP_WR,   4'hC, 32'h0,  1'b0, 32'h0,   1'b0, 32'hA5};
    vecs[9]  = '{OP_WR,   4'h0, 32'h11, 1'b0, 32'h0,   1'b0, 32'hA5};
    vecs[10] = '{OP_IDLE, 4'h0, 32'h0,  1'b0, 32'h0,   1'b0, 32'hA5};
    vecs[11] = '{OP_RD,   4'h4, 32'h0,  1'b0, 32'h100, 1'b0, 32'hA5};
    vecs[12] = '{OP_WR,   4'hC, 32'h1,  1'b0, 32'h0,   1'b0, 32'hA5};
    vecs[13] = '{OP_IDLE, 4'h0, 32'h0,  1'b0, 32'h0,   1'b1, 32'h11};
    vecs[14] = '{OP_RD,   4'h0, 32'h0,  1'b0, 32'h11,  1'b1, 32'h11};
    vecs[15] = '{OP_IDLE, 4'h0, 32'h0,  1'b1, 32'h0,   1'b0, 32'h11};
    vecs[16] = '{OP_RD,   4'h8, 32'h0,  1'b0, 32'h1,   1'b0, 32'h11};

    repeat (3) tick();
    check("reset DataValid", 32'(DataValid), 32'h0);
    check("reset DataOut", DataOut, 32'h0);
    check("reset HRDATA", HRDATA, 32'h0);
    check("HREADYOUT", 32'(HREADYOUT), 32'h1);
    HRESETn = 1'b1;
    tick();

    // reset, first push latency, ENABLE gating
    for (int i = 0; i < 17; i++) begin
      DataReady = vecs[i].ready;
      case (vecs[i].op)
        OP_WR:   ahb_write(vecs[i].addr, vecs[i].wdata);
        OP_RD: begin
          ahb_read(vecs[i].addr, rd);
          check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        end
        default: tick();
      endcase
      check($sformatf("vec%0d DataValid", i), 32'(DataValid), 32'(vecs[i].exp_dv));
      check($sformatf("vec%0d DataOut", i), DataOut, vecs[i].exp_dout);
    end
    DataReady = 1'b0;

    // fill to full, overflow, back-to-back drain
    for (int k = 1; k <= 9; k++) ahb_write(4'h0, 32'(k));
    ahb_read(4'h4, rd);
    check("t2 status full", rd, 32'h805);
    check("t2 DataOut head", DataOut, 32'd1);
    ahb_write(4'h0, 32'd10);
    ahb_read(4'h4, rd);
    check("t2 status overflow", rd, 32'h80D);
    DataReady = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k < 9) begin
        check($sformatf("t2 drain%0d valid", k), 32'(DataValid), 32'h1);
        check($sformatf("t2 drain%0d data", k), DataOut, 32'(k + 1));
      end else begin
        check("t2 drain end valid", 32'(DataValid), 32'h0);
        check("t2 drain end data", DataOut, 32'd9);
      end
    end
    DataReady = 1'b0;
    ahb_read(4'h8, rd);
    check("t2 ack count", rd, 32'd9);
    ahb_read(4'h8, rd);
    check("t2 ack cleared", rd, 32'd0);

    // button mode: glitch rejected, clean press consumes once, DataReady ignored
    ahb_write(4'hC, 32'h3);
    DataReady = 1'b1;
    ahb_write(4'h0, 32'h41);
    ahb_write(4'h0, 32'h42);
    repeat (2) tick();
    check("t3 before data", DataOut, 32'h41);
    Buttons = 1'b1;
    repeat (3) tick();
    Buttons = 1'b0;
    repeat (10) tick();
    check("t3 glitch valid", 32'(DataValid), 32'h1);
    check("t3 glitch data", DataOut, 32'h41);
    Buttons = 1'b1;
    repeat (10) tick();
    Buttons = 1'b0;
    repeat (12) tick();
    check("t3 press valid", 32'(DataValid), 32'h1);
    check("t3 press data", DataOut, 32'h42);
    DataReady = 1'b0;
    ahb_read(4'h8, rd);
    check("t3 ack count", rd, 32'd1);
    ahb_write(4'hC, 32'h1);
    DataReady = 1'b1;
    tick();
    DataReady = 1'b0;
    check("t3 handshake consume", 32'(DataValid), 32'h0);
    ahb_read(4'h8, rd);
    check("t3 ack after mode0", rd, 32'd1);

    // flush with words queued and overflow still set
    for (int k = 0; k < 4; k++) ahb_write(4'h0, 32'h21 + 32'(k));
    ahb_read(4'h4, rd);
    check("t5 status before flush", rd, 32'h309);
    ahb_write(4'hC, 32'h5);
    ahb_read(4'h4, rd);
    check("t5 status after flush", rd, 32'h2);
    check("t5 DataOut kept", DataOut, 32'h21);
    ahb_read(4'hC, rd);
    check("t5 ctrl readback", rd, 32'h1);

    // ACK read coinciding with a consume
    for (int k = 0; k < 4; k++) ahb_write(4'h0, 32'h31 + 32'(k));
    DataReady = 1'b1;
    repeat (3) tick();
    DataReady = 1'b0;
    check("t6 DataOut", DataOut, 32'h34);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8;
    tick();
    HSEL = 1'b0; HTRANS = 2'b00; DataReady = 1'b1;
    rd = HRDATA;
    tick();
    DataReady = 1'b0;
    check("t6 ack read value", rd, 32'd3);
    check("t6 consumed", 32'(DataValid), 32'h0);
    ahb_read(4'h8, rd);
    check("t6 ack after read", rd, 32'd1);

    // asynchronous reset mid-operation
    ahb_write(4'h0, 32'h55);
    tick();
    check("async pre valid", 32'(DataValid), 32'h1);
    @(posedge HCLK);
    #3;
    HRESETn = 1'b0;
    #1;
    check("async valid", 32'(DataValid), 32'h0);
    check("async data", DataOut, 32'h0);
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();

    m_q.delete();
    m_dv = 1'b0; m_dout = 32'd0; m_ovf = 1'b0; m_ack = 0; m_en = 1'b1; m_mode = 1'b0;

    for (int it = 0; it < 400; it++) begin
      int          op;
      logic        txn;
      logic        wr;
      logic [3:0]  a;
      logic [31:0] wd;
      op  = int'($urandom_range(0, 9));
      wd  = $urandom;
      txn = 1'b1;
      wr  = 1'b0;
      a   = 4'h0;
      if (op < 4) begin
        wr = 1'b1;
      end else if (op < 7) begin
        a = 4'($urandom_range(0, 3) << 2);
      end else if (op == 7) begin
        wr = 1'b1;
        a  = 4'hC;
        wd = (($urandom_range(0, 4) == 0) ? 32'h4 : 32'h0) | (($urandom_range(0, 3) != 0) ? 32'h1 : 32'h0);
      end else begin
        txn = 1'b0;
      end

      DataReady = (it < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      check("rnd idle HRDATA", HRDATA, 32'h0);
      check("rnd DataValid", 32'(DataValid), 32'(m_dv));
      check("rnd DataOut", DataOut, m_dout);
      if (txn) begin
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = {28'd0, a};
      end
      @(posedge HCLK);
      model_edge(1'b0, 32'd0, 1'b0, 1'b0, DataReady);
      #1;

      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wd;
      DataReady = (it < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 2) != 0);
      if (txn && !wr) check($sformatf("rnd read addr %h", a), HRDATA, model_read(a[3:2]));
      @(posedge HCLK);
      model_edge(txn && wr && (a == 4'h0), wd, txn && wr && (a == 4'hC),
                 txn && !wr && (a == 4'h8), DataReady);
      #1;
    end
    DataReady = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
